// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one GCD engine among N requesters.
// Grants one job at a time, drives the engine handshake and returns the result with a one-cycle ack.
module gcd_rr_scheduler #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  output logic [N-1:0]         ack,
  output logic [W-1:0]         rsp_gcd,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 eng_start,
  output logic [W-1:0]         eng_a,
  output logic [W-1:0]         eng_b,
  input  logic                 eng_done,
  input  logic [W-1:0]         eng_gcd
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_W = (IW+1)'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] grant_nxt;
  logic [N-1:0]  ack_nxt;
  logic [W-1:0]  gcd_nxt;
  logic [W-1:0]  a_nxt, b_nxt;
  logic          start_nxt;
  logic          busy_nxt;

  logic          pick_vld;
  logic [IW-1:0] pick_id;
  logic [W-1:0]  pick_a, pick_b;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] id);
    return (id == IW'(N-1)) ? '0 : id + IW'(1);
  endfunction

  // Search starts at ptr and wraps; the first requester found wins.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    pick_vld = 1'b0;
    pick_id  = '0;
    sum      = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      cand = sum[IW-1:0];
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_id == IW'(i)) begin
        pick_a = req_a[i*W +: W];
        pick_b = req_b[i*W +: W];
      end
    end
  end

  // DRAIN waits out the engine's second done cycle so start never lands in its FINISH state.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_id;
    ack_nxt   = '0;
    gcd_nxt   = rsp_gcd;
    a_nxt     = eng_a;
    b_nxt     = eng_b;
    start_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_id;
          a_nxt     = pick_a;
          b_nxt     = pick_b;
          start_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = BUSY;
      end
      BUSY: begin
        if (eng_done) begin
          gcd_nxt           = eng_gcd;
          ack_nxt[grant_id] = 1'b1;
          ptr_nxt           = wrap_inc(grant_id);
          state_nxt         = DRAIN;
        end
      end
      DRAIN: begin
        if (!eng_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      ack       <= '0;
      rsp_gcd   <= '0;
      eng_a     <= '0;
      eng_b     <= '0;
      eng_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_id  <= grant_nxt;
      ack       <= ack_nxt;
      rsp_gcd   <= gcd_nxt;
      eng_a     <= a_nxt;
      eng_b     <= b_nxt;
      eng_start <= start_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed bench for gcd_rr_scheduler with a behavioural GCD engine (fixed compute time, done high 2 cycles).
module tb_gcd_rr_scheduler;

  localparam int N       = 4;
  localparam int W       = 16;
  localparam int ENG_LAT = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   ack;
  logic [W-1:0]   rsp_gcd;
  logic [1:0]     grant_id;
  logic           busy, eng_start;
  logic [W-1:0]   eng_a, eng_b;
  logic           eng_done;
  logic [W-1:0]   eng_gcd;

  int errors = 0;
  int checks = 0;

  int         start_cnt = 0;
  logic [W-1:0] st_a, st_b;
  int         ack_twice = 0;
  int         ack_multi = 0;
  bit         prev_ack_nz = 1'b0;

  gcd_rr_scheduler #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .rsp_gcd(rsp_gcd), .grant_id(grant_id), .busy(busy),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_gcd(eng_gcd)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine model: WAIT -> CALC (ENG_LAT cycles) -> FIN (done high 2 cycles) -> WAIT.
  typedef enum {E_WAIT, E_CALC, E_FIN} est_t;
  est_t         est = E_WAIT;
  int           ecnt = 0;
  logic [W-1:0] eres = '0;

  always @(posedge clk) begin
    if (rst) begin
      est      <= E_WAIT;
      eng_done <= 1'b0;
      eng_gcd  <= '0;
      ecnt     <= 0;
    end else begin
      case (est)
        E_WAIT: if (eng_start === 1'b1) begin
          eres <= gcd_f(eng_a, eng_b);
          ecnt <= ENG_LAT;
          est  <= E_CALC;
        end
        E_CALC: if (ecnt == 1) begin
          eng_done <= 1'b1;
          eng_gcd  <= eres;
          ecnt     <= 2;
          est      <= E_FIN;
        end else begin
          ecnt <= ecnt - 1;
        end
        E_FIN: if (ecnt == 1) begin
          eng_done <= 1'b0;
          est      <= E_WAIT;
        end else begin
          ecnt <= ecnt - 1;
        end
        default: est <= E_WAIT;
      endcase
    end
  end

  always @(posedge clk) begin
    if (eng_start === 1'b1) begin
      start_cnt = start_cnt + 1;
      st_a = eng_a;
      st_b = eng_b;
    end
    if ((ack != 0) && prev_ack_nz) ack_twice = ack_twice + 1;
    if ((ack != 0) && !$onehot(ack)) ack_multi = ack_multi + 1;
    prev_ack_nz = (ack != 0);
  end

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic [N-1:0] a, output logic [W-1:0] g);
    a = '0;
    g = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ack != 0) begin
        a = ack;
        g = rsp_gcd;
        break;
      end
    end
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (eng_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy === 1'b0) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = 4'b1111;
    req_a = {16'd5, 16'd6, 16'd7, 16'd8};
    req_b = {16'd3, 16'd3, 16'd3, 16'd3};
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack cyc%0d: got %b expected 0000", c, ack); end
      checks++;
      if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_start cyc%0d: got %b expected 0", c, eng_start); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d: got %b expected 0", c, busy); end
    end
    checks++;
    if (rsp_gcd !== 16'd0) begin errors++; $display("FAIL reset_rsp: got %0d expected 0", rsp_gcd); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    checks++;
    if ({eng_a, eng_b} !== 32'd0) begin errors++; $display("FAIL reset_eng_ops: got %0d/%0d expected 0/0", eng_a, eng_b); end
    req = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_job();
    logic [N-1:0] a;
    logic [W-1:0] g;
    int s0;
    s0 = start_cnt;
    set_ops(2, 16'd48, 16'd18);
    req = 4'b0100;
    wait_ack(a, g);
    req = '0;
    checks++;
    if (a !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", a); end
    checks++;
    if (g !== 16'd6) begin errors++; $display("FAIL single_gcd: got %0d expected 6", g); end
    checks++;
    if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", grant_id); end
    checks++;
    if (start_cnt !== s0 + 1) begin errors++; $display("FAIL single_start_pulses: got %0d expected %0d", start_cnt - s0, 1); end
    checks++;
    if ({st_a, st_b} !== {16'd48, 16'd18}) begin errors++; $display("FAIL single_eng_ops: got %0d/%0d expected 48/18", st_a, st_b); end
    tick();
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_width: got %b expected 0000", ack); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_drain: got %b expected 1", busy); end
    wait_idle();
    checks++;
    if ({busy, eng_done} !== 2'b00) begin errors++; $display("FAIL single_idle: got busy=%b done=%b expected 0/0", busy, eng_done); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] a;
    logic [W-1:0] g;
    logic [N-1:0] exp_ack [5];
    logic [W-1:0] exp_g [5];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_g   = '{16'd4, 16'd7, 16'd1, 16'd9, 16'd4};
    do_reset();
    set_ops(0, 16'd12, 16'd8);
    set_ops(1, 16'd35, 16'd14);
    set_ops(2, 16'd17, 16'd5);
    set_ops(3, 16'd0, 16'd9);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ack(a, g);
      if (j == 4) req = '0;
      checks++;
      if (a !== exp_ack[j]) begin errors++; $display("FAIL rr_ack job%0d: got %b expected %b", j, a, exp_ack[j]); end
      checks++;
      if (g !== exp_g[j]) begin errors++; $display("FAIL rr_gcd job%0d: got %0d expected %0d", j, g, exp_g[j]); end
    end
    wait_idle();
  endtask

  task automatic test_zero_edge();
    logic [N-1:0] a;
    logic [W-1:0] g;
    set_ops(1, 16'd0, 16'd0);
    req = 4'b0010;
    wait_ack(a, g);
    set_ops(1, 16'd65535, 16'd0);
    checks++;
    if (a !== 4'b0010) begin errors++; $display("FAIL zero00_ack: got %b expected 0010", a); end
    checks++;
    if (g !== 16'd0) begin errors++; $display("FAIL zero00_gcd: got %0d expected 0", g); end
    tick();
    checks++;
    if ({ack, rsp_gcd} !== {4'b0000, 16'd0}) begin errors++; $display("FAIL zero_hold: got ack=%b rsp=%0d expected 0000/0", ack, rsp_gcd); end
    wait_ack(a, g);
    req = '0;
    checks++;
    if (a !== 4'b0010) begin errors++; $display("FAIL zeromax_ack: got %b expected 0010", a); end
    checks++;
    if (g !== 16'd65535) begin errors++; $display("FAIL zeromax_gcd: got %0d expected 65535", g); end
    wait_idle();
  endtask

  task automatic test_operand_change();
    logic [N-1:0] a;
    logic [W-1:0] g;
    bit seen;
    set_ops(0, 16'd100, 16'd75);
    req = 4'b0001;
    wait_start(seen);
    req_a[0 +: W] = 16'd7;
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL opchg_start: got %b expected 1", seen); end
    wait_ack(a, g);
    req = '0;
    checks++;
    if (a !== 4'b0001) begin errors++; $display("FAIL opchg_ack: got %b expected 0001", a); end
    checks++;
    if (g !== 16'd25) begin errors++; $display("FAIL opchg_gcd: got %0d expected 25", g); end
    checks++;
    if (st_a !== 16'd100) begin errors++; $display("FAIL opchg_eng_a: got %0d expected 100", st_a); end
    wait_idle();
  endtask

  task automatic test_reset_mid_busy();
    logic [N-1:0] a;
    logic [W-1:0] g;
    bit seen;
    set_ops(0, 16'd1000, 16'd3);
    req = 4'b0001;
    wait_start(seen);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL midrst_start: got %b expected 1", seen); end
    tick();
    tick();
    rst = 1'b1;
    req = 4'b1000;
    set_ops(3, 16'd21, 16'd14);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({ack, busy, eng_start} !== 6'b0) begin errors++; $display("FAIL midrst_quiet cyc%0d: got ack=%b busy=%b start=%b expected 0", c, ack, busy, eng_start); end
    end
    rst = 1'b0;
    wait_ack(a, g);
    req = '0;
    checks++;
    if (a !== 4'b1000) begin errors++; $display("FAIL midrst_ack: got %b expected 1000", a); end
    checks++;
    if (g !== 16'd7) begin errors++; $display("FAIL midrst_gcd: got %0d expected 7", g); end
    checks++;
    if (grant_id !== 2'd3) begin errors++; $display("FAIL midrst_grant: got %0d expected 3", grant_id); end
    wait_idle();
  endtask

  task automatic test_ack_shape();
    checks++;
    if (ack_twice !== 0) begin errors++; $display("FAIL ack_consecutive: got %0d expected 0", ack_twice); end
    checks++;
    if (ack_multi !== 0) begin errors++; $display("FAIL ack_onehot: got %0d expected 0", ack_multi); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_zero_edge();
    test_operand_change();
    test_reset_mid_busy();
    test_ack_shape();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
